latch_bank_sched: RTL
=====================

// Module: latch_bank_sched
// PURPOSE
//  Round-robin scheduler sharing one bank of NUM_LAT D-latches (DATA_W wide each) among NUM_REQ requesters.
//  Per granted write it sequences a glitch-free enable: data setup, enable open, then data hold.
//  Sits between requesting blocks and the latch bank's en_i/d_i pins; latches are level-sensitive, so all timing is owned here.
// PARAMETERS
//  NUM_REQ   4  number of requesters (>=2)
//  NUM_LAT   4  number of latches in bank; AW = $clog2(NUM_LAT)
//  DATA_W    8  latch data width
//  OPEN_CYC  2  cycles enable is held high (>=1)
// PORTS
//  clk_i      in   1               clock, rising edge
//  rst_ni     in   1               async reset, active low
//  req_i      in   NUM_REQ         write request, level, held until ack
//  addr_i     in   NUM_REQ*AW      per-requester latch index, slice r = [r*AW +: AW]
//  data_i     in   NUM_REQ*DATA_W  per-requester write data, slice r
//  ack_o      out  NUM_REQ         one-cycle completion pulse to granted requester
//  busy_o     out  1               high in any state except IDLE
//  gnt_id_o   out  $clog2(NUM_REQ) index of current/last granted requester
//  lat_en_o   out  NUM_LAT         one-hot (or zero) enable to latch bank, registered
//  lat_d_o    out  DATA_W          data to latch bank, registered
//  lat_q_i    in   NUM_LAT*DATA_W  latch outputs (only with LATCH_READBACK_EN)
//  err_o      out  1               readback mismatch pulse (only with LATCH_READBACK_EN)
// BEHAVIOUR
//  - Reset (async, rst_ni=0): state IDLE, ack_o=0, busy_o=0, gnt_id_o=0, lat_en_o=0, lat_d_o=0, err_o=0, rr pointer=0.
//  - FSM: IDLE -> SETUP -> OPEN -> HOLD -> IDLE.
//  - IDLE: if any req_i, grant first requester at or after rr pointer (wrapping NUM_REQ-1 -> 0).
//    Capture addr/data into internal regs, drive lat_d_o, set gnt_id_o. Go to SETUP. lat_en_o stays 0.
//  - SETUP (1 cycle): lat_d_o stable, lat_en_o=0. Go to OPEN.
//  - OPEN (OPEN_CYC cycles, counter): lat_en_o = one-hot(captured addr); lat_d_o unchanged.
//  - HOLD (1 cycle): lat_en_o=0, lat_d_o unchanged. ack_o[gnt]=1 this cycle.
//    Then rr pointer = gnt+1 (wrap); go to IDLE.
//  - Latency: grant cycle to ack = 2 + OPEN_CYC cycles; back-to-back requests give one IDLE cycle between transactions.
//  - lat_d_o never changes while any lat_en_o bit is high; enable never rises/falls in the same cycle as data changes.
//  - Captured address >= NUM_LAT (non-power-of-2 bank): no enable asserted; sequence and ack still complete.
//  - req_i/addr_i/data_i changes after grant are ignored until the next IDLE arbitration.
//  - Requester dropping req_i before ack: transaction still completes; ack still pulses.
//  - Simultaneous requests: exactly one grant per arbitration; no requester starves (max wait NUM_REQ-1 transactions).
//  - Reset mid-transaction: lat_en_o drops to 0 immediately (async); no ack issued for aborted write.
// CONFIGURATION
//  LATCH_READBACK_EN defined:
//    - HOLD extends by one cycle (VERIFY). In VERIFY, compare lat_q_i slice[addr] to captured data.
//    - err_o pulses with ack_o on mismatch; latency = 3 + OPEN_CYC.
//  LATCH_READBACK_EN undefined:
//    - lat_q_i and err_o not present; no VERIFY state.
// TESTING
//  1. Reset, req_i=4'b0001, addr0=2, data0=8'hA5
//     -> lat_d_o=A5 at SETUP; lat_en_o=4'b0100 for 2 cycles; ack_o=4'b0001 4 cycles after grant.
//  2. req_i=4'b1111 held, distinct data
//     -> grants in order 0,1,2,3,0; each ack one-hot; one IDLE cycle between transactions.
//  3. Change data_i/addr_i of granted requester during OPEN
//     -> lat_d_o and lat_en_o unchanged; bank model latch holds the captured value.
//  4. Assert rst_ni=0 during OPEN
//     -> lat_en_o=0 same cycle; no ack; after release, state IDLE and gnt_id_o=0.
//  5. With LATCH_READBACK_EN, bank model forces lat_q bit flip on addr 1
//     -> err_o=1 coincident with ack; correct readback -> err_o=0.
//  6. Every cycle, check assertions:
//     - lat_en_o is $onehot0.
//     - lat_d_o is stable whenever lat_en_o != 0, and in the cycles before/after.
//     - No starvation exceeds NUM_REQ-1 transactions.

Source files
------------

// File: rtl/latch_bank_sched.sv
// latch_bank_sched: round-robin scheduler sharing one bank of level-sensitive
// D-latches among several requesters. Each granted write runs a glitch-free
// enable sequence: data setup, enable open for OPEN_CYC cycles, then data hold.
// Optional feature macro: LATCH_READBACK_EN adds a VERIFY cycle that compares
// the addressed latch output (lat_q_i) against the written data and flags err_o.
module latch_bank_sched #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_LAT  = 4,
  parameter int DATA_W   = 8,
  parameter int OPEN_CYC = 2,
  localparam int AW = $clog2(NUM_LAT),
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*AW-1:0]     addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic                      busy_o,
  output logic [GW-1:0]             gnt_id_o,
  output logic [NUM_LAT-1:0]        lat_en_o,
  output logic [DATA_W-1:0]         lat_d_o
`ifdef LATCH_READBACK_EN
  ,
  input  logic [NUM_LAT*DATA_W-1:0] lat_q_i,
  output logic                      err_o
`endif
);

  localparam int CW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;

  // S_VERIFY is only reachable when readback checking is compiled in.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_OPEN,
    S_HOLD,
    S_VERIFY
  } state_t;

`ifdef LATCH_READBACK_EN
  localparam state_t S_ACK = S_VERIFY;
`else
  localparam state_t S_ACK = S_HOLD;
`endif

  state_t          state_q;
  state_t          state_nxt;
  logic [CW-1:0]   cnt_q;
  logic [GW-1:0]   rr_q;
  logic [GW-1:0]   gnt_q;
  logic [AW-1:0]   addr_q;
  logic            win_found;
  logic [GW-1:0]   win_id;
  logic [NUM_REQ-1:0] req_rot;
  logic [GW:0]     win_sum;

  // Decode a captured latch index into a one-hot enable; out-of-range indices
  // (possible with a non-power-of-2 bank) decode to all zeros.
  function automatic logic [NUM_LAT-1:0] addr_onehot(input logic [AW-1:0] a);
    logic [NUM_LAT-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_LAT; i++) begin
      if (int'(a) == i) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Round-robin pick: first requester at or after rr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_sum   = '0;
    req_rot   = NUM_REQ'({req_i, req_i} >> rr_q);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_rot[k]) begin
        win_found = 1'b1;
        win_sum   = {1'b0, rr_q} + (GW+1)'(k);
        if (win_sum >= (GW+1)'(NUM_REQ)) win_sum = win_sum - (GW+1)'(NUM_REQ);
        win_id    = win_sum[GW-1:0];
      end
    end
  end

  // Next-state logic for the write sequence.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:   if (win_found) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_OPEN;
      S_OPEN:   if (cnt_q == CW'(OPEN_CYC - 1)) state_nxt = S_HOLD;
`ifdef LATCH_READBACK_EN
      S_HOLD:   state_nxt = S_VERIFY;
`else
      S_HOLD:   state_nxt = S_IDLE;
`endif
      S_VERIFY: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_nxt;
  end

  // Sequencing counters, grant bookkeeping and registered latch-bank outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      rr_q     <= '0;
      gnt_q    <= '0;
      lat_d_o  <= '0;
      lat_en_o <= '0;
      ack_o    <= '0;
    end else begin
      cnt_q    <= (state_q == S_OPEN) ? cnt_q + 1'b1 : '0;
      lat_en_o <= (state_nxt == S_OPEN) ? addr_onehot(addr_q) : '0;
      ack_o    <= (state_nxt == S_ACK) ? (NUM_REQ'(1) << gnt_q) : '0;
      if (state_q == S_IDLE && win_found) begin
        gnt_q   <= win_id;
        lat_d_o <= data_i[int'(win_id)*DATA_W +: DATA_W];
      end
      if (state_q == S_ACK) begin
        rr_q <= (gnt_q == GW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
      end
    end
  end

  // Captured latch index; only consumed while the sequence is running.
  always_ff @(posedge clk_i) begin
    if (state_q == S_IDLE && win_found) addr_q <= addr_i[int'(win_id)*AW +: AW];
  end

`ifdef LATCH_READBACK_EN
  // Latches are closed during HOLD, so their outputs are final there; the
  // comparison is registered so err_o lines up with the VERIFY-cycle ack.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_o <= 1'b0;
    else         err_o <= (state_nxt == S_VERIFY) && (int'(addr_q) < NUM_LAT) &&
                          (lat_q_i[int'(addr_q)*DATA_W +: DATA_W] != lat_d_o);
  end
`endif

  assign busy_o   = (state_q != S_IDLE);
  assign gnt_id_o = gnt_q;

endmodule
